// File: rtl/wb_pkg.sv
// Shared Wishbone master definitions: FSM state encoding and default bus geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

   localparam int WB_ADDR_W  = 32;
   localparam int WB_DATA_W  = 32;
   localparam int WB_TIMEOUT = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_master_if_if.sv
// Wishbone classic bus bundle between one initiator and the interconnect.
// Latency: n/a (wires only).
// Backpressure: slave stalls the initiator by withholding ack_i.
interface wb_master_if_if
   import wb_pkg::*;
#(
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W
);

   logic                  cyc_o;
   logic                  stb_o;
   logic                  we_o;
   logic [ADDR_W-1:0]     adr_o;
   logic [DATA_W-1:0]     dat_o;
   logic [DATA_W/8-1:0]   sel_o;
   logic [DATA_W-1:0]     dat_i;
   logic                  ack_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      output dat_i, ack_i
   );

endinterface

// File: rtl/wb_master_if.sv
// Wishbone classic single-transfer initiator with ACK timeout abort.
// Latency: req accepted at edge n drives STB from n; ACK sampled at edge m gives done_o after m.
// Backpressure: req_i is only sampled while idle; the slave stalls by withholding ack_i.
module wb_master_if
   import wb_pkg::*;
#(
   parameter int ADDR_W  = WB_ADDR_W,
   parameter int DATA_W  = WB_DATA_W,
   parameter int TIMEOUT = WB_TIMEOUT
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                req_we_i,
   input  logic [ADDR_W-1:0]   req_adr_i,
   input  logic [DATA_W-1:0]   req_dat_i,
   input  logic [DATA_W/8-1:0] req_sel_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   output logic [DATA_W-1:0]   rdat_o,
   wb_master_if_if.master      wb
);

   localparam int SEL_W = DATA_W / 8;
   localparam int TO_W  = $clog2(TIMEOUT);
   // Last counter value before abort: STB is then high for exactly TIMEOUT cycles.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   wb_state_e         state_q, state_d;
   logic [TO_W-1:0]   cnt_q,   cnt_d;
   logic              cyc_q,   cyc_d;
   logic              we_q,    we_d;
   logic [ADDR_W-1:0] adr_q,   adr_d;
   logic [DATA_W-1:0] dat_q,   dat_d;
   logic [SEL_W-1:0]  sel_q,   sel_d;
   logic              done_q,  done_d;
   logic              err_q,   err_d;
   logic [DATA_W-1:0] rdat_q,  rdat_d;

   // Next-state and next-output computation; every output comes from a flop below.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      rdat_d  = rdat_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // ack_i is deliberately ignored here.
            if (req_i) begin
               state_d = ST_BUS;
               cyc_d   = 1'b1;
               we_d    = req_we_i;
               adr_d   = req_adr_i;
               dat_d   = req_dat_i;
               sel_d   = req_sel_i;
               cnt_d   = '0;
            end
         end

         ST_BUS: begin
            // ACK is checked first so a late ACK on the final cycle still completes cleanly.
            if (wb.ack_i) begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
               done_d  = 1'b1;
               if (!we_q) begin
                  rdat_d = wb.dat_i;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               rdat_d  = '0;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops any transfer in flight without a done pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
      end
   end

   // CYC and STB are one flop: this initiator never idles STB inside a cycle.
   assign wb.cyc_o = cyc_q;
   assign wb.stb_o = cyc_q;
   assign wb.we_o  = we_q;
   assign wb.adr_o = adr_q;
   assign wb.dat_o = dat_q;
   assign wb.sel_o = sel_q;

   assign busy_o = (state_q != ST_IDLE);
   assign done_o = done_q;
   assign err_o  = err_q;
   assign rdat_o = rdat_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Scoreboard bench for wb_master_if: directed transfers against a delay-programmable slave.
// Latency: n/a (testbench).
// Backpressure: the slave model withholds ack_i for a per-transfer number of STB cycles.
module tb_wb_master_if;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   typedef struct {
      logic          we;
      logic [31:0]   adr;
      logic [31:0]   dat;
      logic [3:0]    sel;
      logic          err;
      logic [31:0]   rdat;
      int            stbn;
      int            gap;
   } exp_t;

   logic          clk;
   logic          rst_ni;
   logic          req_i;
   logic          req_we_i;
   logic [31:0]   req_adr_i;
   logic [31:0]   req_dat_i;
   logic [3:0]    req_sel_i;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [31:0]   rdat_o;

   int            total = 0;
   int            bad   = 0;
   exp_t          q[$];
   int            ack_delay = 1;
   logic [31:0]   slv_rdata = 32'h0;
   bit            ack_idle  = 1'b0;
   logic [31:0]   exp_rdat  = 32'h0;

   wb_master_if_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   wb_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .req_we_i  (req_we_i),
      .req_adr_i (req_adr_i),
      .req_dat_i (req_dat_i),
      .req_sel_i (req_sel_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .rdat_o    (rdat_o),
      .wb        (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm, input string why);
      total++;
      bad++;
      $display("FAIL %s: %s", nm, why);
   endtask

   // Slave: acks once STB has been high for ack_delay+1 cycles; returns junk except on read ACK.
   initial begin : slave
      int stb_cnt;
      stb_cnt   = 0;
      bus.ack_i = 1'b0;
      bus.dat_i = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.stb_o) begin
            stb_cnt++;
            bus.ack_i = (stb_cnt == ack_delay + 1);
         end else begin
            stb_cnt   = 0;
            bus.ack_i = ack_idle;
         end
         bus.dat_i = (bus.ack_i && bus.stb_o && !bus.we_o) ? slv_rdata : 32'hBAD0_BAD0;
      end
   end

   // Monitor: checks bus fields during STB and pops the scoreboard on every done_o.
   initial begin : monitor
      exp_t e;
      int   stbn;
      int   low_cnt;
      bit   started;
      stbn    = 0;
      low_cnt = 1000;
      started = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            if (started && q.size() > 0) e = q.pop_front();
            started = 1'b0;
            stbn    = 0;
         end else begin
            chk("busy_vs_stb", busy_o, bus.stb_o);
            chk("cyc_eq_stb", bus.cyc_o, bus.stb_o);
            if (bus.stb_o) begin
               if (q.size() == 0) begin
                  fail("stb_unexpected", "stb_o high with no request outstanding");
               end else begin
                  e = q[0];
                  if (!started) begin
                     started = 1'b1;
                     stbn    = 0;
                     if (e.gap >= 0) chk("cyc_gap", low_cnt, e.gap);
                     low_cnt = 0;
                  end
                  chk("we_o",  bus.we_o,  e.we);
                  chk("adr_o", bus.adr_o, e.adr);
                  chk("dat_o", bus.dat_o, e.dat);
                  chk("sel_o", bus.sel_o, e.sel);
               end
               stbn++;
            end else begin
               low_cnt++;
            end
            if (done_o) begin
               if (q.size() == 0) begin
                  fail("done_unexpected", "done_o pulse with no request outstanding");
               end else begin
                  e = q.pop_front();
                  chk("err_o", err_o, e.err);
                  chk("rdat_o", rdat_o, e.rdat);
                  chk("stb_cycles", stbn, e.stbn);
               end
               started = 1'b0;
               stbn    = 0;
            end else begin
               chk("err_without_done", err_o, 0);
            end
         end
      end
   end

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (busy_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy_o) fail(nm, "busy_o never dropped");
   endtask

   // Presents one request once the master is idle; hold keeps req_i high for a follow-on request.
   task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly, input logic [31:0] rd,
                        input bit hold, input int gap);
      exp_t e;
      wait_idle("idle_before_req");
      e.we  = we;
      e.adr = adr;
      e.dat = dat;
      e.sel = sel;
      e.gap = gap;
      if (dly < TO) begin
         e.stbn = dly + 1;
         e.err  = 1'b0;
         if (!we) exp_rdat = rd;
      end else begin
         e.stbn   = TO;
         e.err    = 1'b1;
         exp_rdat = 32'h0;
      end
      e.rdat    = exp_rdat;
      ack_delay = dly;
      slv_rdata = rd;
      req_we_i  = we;
      req_adr_i = adr;
      req_dat_i = dat;
      req_sel_i = sel;
      req_i     = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      chk("req_accept", busy_o, 1);
      if (!hold) req_i = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin : stim
      rst_ni    = 1'b0;
      req_i     = 1'b0;
      req_we_i  = 1'b0;
      req_adr_i = 32'h0;
      req_dat_i = 32'h0;
      req_sel_i = 4'h0;
      repeat (2) @(negedge clk);
      chk("rst_cyc",  bus.cyc_o, 0);
      chk("rst_stb",  bus.stb_o, 0);
      chk("rst_we",   bus.we_o,  0);
      chk("rst_adr",  bus.adr_o, 0);
      chk("rst_dat",  bus.dat_o, 0);
      chk("rst_sel",  bus.sel_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err",  err_o,  0);
      chk("rst_rdat", rdat_o, 0);
      #2 rst_ni = 1'b1;

      // Write, read with ACK one cycle after STB.
      issue(1'b1, 32'h400, 32'h0000_00A5, 4'hF, 1, 32'h0, 1'b0, -1);
      issue(1'b0, 32'h400, 32'h0,         4'hF, 1, 32'h0000_00A5, 1'b0, -1);
      wait_idle("idle_after_read");
      repeat (3) @(negedge clk);
      chk("rdat_hold", rdat_o, 32'h0000_00A5);

      // Read to a slave that never acks: abort after TIMEOUT STB cycles.
      issue(1'b0, 32'h404, 32'h0, 4'hF, 100, 32'h5555_5555, 1'b0, -1);

      // Back-to-back writes with req_i held high: one idle cycle between them.
      issue(1'b1, 32'h400, 32'h0000_0001, 4'hF, 1, 32'h0, 1'b1, -1);
      issue(1'b1, 32'h400, 32'h0000_0002, 4'hF, 1, 32'h0, 1'b0, 1);

      // ACK on the last allowed STB cycle wins over the timeout.
      issue(1'b0, 32'h408, 32'h0, 4'h3, TO - 1, 32'h1234_5678, 1'b0, -1);

      // A write must leave the last read data untouched.
      issue(1'b1, 32'h40C, 32'hDEAD_0001, 4'hC, 3, 32'h0, 1'b0, -1);
      wait_idle("idle_after_write");

      // Stray ACK while idle must not start or complete anything.
      ack_idle = 1'b1;
      repeat (3) @(negedge clk);
      ack_idle = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ack_busy", busy_o, 0);
      chk("idle_ack_rdat", rdat_o, 32'h1234_5678);

      // Reset while STB is high: everything clears immediately, no done_o.
      issue(1'b0, 32'h800, 32'h0, 4'hF, 100, 32'h0, 1'b0, -1);
      repeat (3) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_cyc",  bus.cyc_o, 0);
      chk("midrst_stb",  bus.stb_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_rdat", rdat_o, 0);
      @(negedge clk);
      #2 rst_ni = 1'b1;
      exp_rdat = 32'h0;

      // Normal operation after reset.
      issue(1'b1, 32'h10, 32'h0000_BEEF, 4'h1, 2, 32'h0, 1'b0, -1);
      issue(1'b0, 32'h14, 32'h0,         4'hF, 1, 32'hCAFE_F00D, 1'b0, -1);
      wait_idle("idle_at_end");
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
